// File: rtl/conv_load_sequencer.sv
// Moves one conv layer's bias, weight and layer-buffer words from the PCIe
// receive stream into their stores, in that order, and pulses loadDone at the end.
module conv_load_sequencer #(
    parameter int unsigned BIAS_CNT_W   = 8,
    parameter int unsigned WEIGHT_CNT_W = 16,
    parameter int unsigned LAYER_ADDR_W = 12,
    parameter int unsigned DATA_W       = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic                    start,
    input  logic [BIAS_CNT_W-1:0]   biasNum,
    input  logic [WEIGHT_CNT_W-1:0] weightNum,
    input  logic [LAYER_ADDR_W-1:0] layerNum,
    input  logic                    pcieValid,
    input  logic [DATA_W-1:0]       pcieData,
    output logic                    pcieReady,
    input  logic                    biasFull,
    input  logic                    weightFull,
    output logic                    biasWrEn,
    output logic                    weightWrEn,
    output logic                    layerEna,
    output logic                    layerWea,
    output logic [LAYER_ADDR_W-1:0] layerAddr,
    output logic [DATA_W-1:0]       wrData,
    output logic [2:0]              loadState,
    output logic                    loadDone
);

    typedef enum logic [2:0] {
        IDLE   = 3'b000,
        BIAS   = 3'b001,
        WEIGHT = 3'b010,
        LAYER  = 3'b011,
        DONE   = 3'b100
    } state_t;

    state_t                  state;
    logic [BIAS_CNT_W-1:0]   remB;
    logic [WEIGHT_CNT_W-1:0] remW;
    logic [LAYER_ADDR_W-1:0] remL;
    logic                    acc;

    // Ready reflects remaining words and downstream room for the active stage
    always_comb begin
        pcieReady = 1'b0;
        case (state)
            BIAS:    pcieReady = ena && (remB != '0) && !biasFull;
            WEIGHT:  pcieReady = ena && (remW != '0) && !weightFull;
            LAYER:   pcieReady = ena && (remL != '0);
            default: pcieReady = 1'b0;
        endcase
    end

    assign acc        = ena && pcieValid && pcieReady;
    assign biasWrEn   = acc && (state == BIAS);
    assign weightWrEn = acc && (state == WEIGHT);
    assign layerEna   = acc && (state == LAYER);
    assign layerWea   = layerEna;
    assign wrData     = pcieData;
    assign loadState  = state;
    assign loadDone   = (state == DONE);

    // A stage ends once its remaining count is zero after this cycle's accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remB      <= '0;
            remW      <= '0;
            remL      <= '0;
            layerAddr <= '0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        remB      <= biasNum;
                        remW      <= weightNum;
                        remL      <= layerNum;
                        layerAddr <= '0;
                        state     <= BIAS;
                    end
                end
                BIAS: begin
                    if (acc) remB <= remB - BIAS_CNT_W'(1);
                    if ((remB == '0) || ((remB == BIAS_CNT_W'(1)) && acc)) state <= WEIGHT;
                end
                WEIGHT: begin
                    if (acc) remW <= remW - WEIGHT_CNT_W'(1);
                    if ((remW == '0) || ((remW == WEIGHT_CNT_W'(1)) && acc)) state <= LAYER;
                end
                LAYER: begin
                    if (acc) begin
                        remL      <= remL - LAYER_ADDR_W'(1);
                        layerAddr <= layerAddr + LAYER_ADDR_W'(1);
                    end
                    if ((remL == '0) || ((remL == LAYER_ADDR_W'(1)) && acc)) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_load_sequencer.sv
// Bench for conv_load_sequencer: stage-level reference model checked every
// cycle, plus directed load scenarios with hand-computed expectations.
module tb_conv_load_sequencer;

    localparam int unsigned BW = 8;
    localparam int unsigned WW = 16;
    localparam int unsigned LW = 12;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ena = 1'b0;
    logic          start = 1'b0;
    logic [BW-1:0] biasNum = '0;
    logic [WW-1:0] weightNum = '0;
    logic [LW-1:0] layerNum = '0;
    logic          pcieValid = 1'b0;
    logic [DW-1:0] pcieData = '0;
    logic          pcieReady;
    logic          biasFull = 1'b0;
    logic          weightFull = 1'b0;
    logic          biasWrEn, weightWrEn, layerEna, layerWea;
    logic [LW-1:0] layerAddr;
    logic [DW-1:0] wrData;
    logic [2:0]    loadState;
    logic          loadDone;

    conv_load_sequencer #(
        .BIAS_CNT_W(BW), .WEIGHT_CNT_W(WW), .LAYER_ADDR_W(LW), .DATA_W(DW)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena), .start(start),
        .biasNum(biasNum), .weightNum(weightNum), .layerNum(layerNum),
        .pcieValid(pcieValid), .pcieData(pcieData), .pcieReady(pcieReady),
        .biasFull(biasFull), .weightFull(weightFull),
        .biasWrEn(biasWrEn), .weightWrEn(weightWrEn),
        .layerEna(layerEna), .layerWea(layerWea), .layerAddr(layerAddr),
        .wrData(wrData), .loadState(loadState), .loadDone(loadDone)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1..3 the three stages, 4 done
    int mPh = 0, mAddr = 0;
    int mRem [3] = '{0, 0, 0};
    int nPh = 0, nAddr = 0;
    int nRem [3] = '{0, 0, 0};

    always @(negedge clk) begin
        int  idx;
        bit  full, eReady, eAcc;
        if (rst) begin
            mPh = 0; mAddr = 0; mRem = '{0, 0, 0};
        end else begin
            mPh = nPh; mAddr = nAddr; mRem = nRem;
        end
        idx = 0;
        eReady = 1'b0;
        if (mPh >= 1 && mPh <= 3) begin
            idx    = mPh - 1;
            full   = (mPh == 1) ? biasFull : (mPh == 2) ? weightFull : 1'b0;
            eReady = ena && (mRem[idx] != 0) && !full;
        end
        eAcc = eReady && pcieValid;
        chk("pcieReady",  32'(pcieReady),  32'(eReady));
        chk("biasWrEn",   32'(biasWrEn),   32'(eAcc && mPh == 1));
        chk("weightWrEn", 32'(weightWrEn), 32'(eAcc && mPh == 2));
        chk("layerEna",   32'(layerEna),   32'(eAcc && mPh == 3));
        chk("layerWea",   32'(layerWea),   32'(eAcc && mPh == 3));
        chk("loadState",  32'(loadState),  32'(mPh));
        chk("loadDone",   32'(loadDone),   32'(mPh == 4));
        chk("layerAddr",  32'(layerAddr),  32'(mAddr));
        chk("wrData",     wrData,          pcieData);
        nPh = mPh; nAddr = mAddr; nRem = mRem;
        if (!rst && ena) begin
            if (mPh == 0) begin
                if (start) begin
                    nRem  = '{int'(biasNum), int'(weightNum), int'(layerNum)};
                    nAddr = 0;
                    nPh   = 1;
                end
            end else if (mPh == 4) begin
                nPh = 0;
            end else begin
                if (eAcc) begin
                    nRem[idx] = nRem[idx] - 1;
                    if (mPh == 3) nAddr = (nAddr + 1) % (1 << LW);
                end
                if (nRem[idx] == 0) nPh = mPh + 1;
            end
        end
    end

    // Observations from the most recent load
    int nBias, nWeight, nLayer, nReady, doneAt, doneLen, weightCycles, stallWrites, enaLowBad;
    bit layerAddrOk;
    logic [31:0] seq;

    // mode: 0 plain, 1 bias full stall, 2 ena drop, 3 stray start, 4 reset mid-layer
    task automatic runLoad(input int b, input int w, input int l, input int mode);
        int  lastState;
        bit  quit;
        nBias = 0; nWeight = 0; nLayer = 0; nReady = 0; doneAt = 0; doneLen = 0;
        weightCycles = 0; stallWrites = 0; enaLowBad = 0; layerAddrOk = 1'b1;
        seq = '0; lastState = 0; quit = 1'b0;
        @(posedge clk); #1;
        biasNum = BW'(b); weightNum = WW'(w); layerNum = LW'(l);
        start = 1'b1; ena = 1'b1; pcieValid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 40 && !quit; k++) begin
            @(negedge clk);
            if (biasWrEn) begin nBias++; if (biasFull) stallWrites++; end
            if (weightWrEn) nWeight++;
            if (layerEna) begin
                if (int'(layerAddr) != nLayer) layerAddrOk = 1'b0;
                nLayer++;
            end
            if (pcieReady) nReady++;
            if (loadState == 3'd2) weightCycles++;
            if (int'(loadState) != lastState) begin
                seq = {seq[27:0], 1'b0, loadState};
                lastState = int'(loadState);
            end
            if (loadDone) begin if (doneAt == 0) doneAt = k; doneLen++; end
            if (!ena && (pcieReady || loadState != 3'd2)) enaLowBad++;
            if (doneAt != 0 && !loadDone) quit = 1'b1;
            if (mode == 4 && k == 7 && !quit) begin
                @(posedge clk); #3;
                rst = 1'b1;
                #1;
                chk("rst loadState", 32'(loadState), 32'd0);
                chk("rst pcieReady", 32'(pcieReady), 32'd0);
                chk("rst layerEna",  32'(layerEna),  32'd0);
                chk("rst layerAddr", 32'(layerAddr), 32'd0);
                chk("rst loadDone",  32'(loadDone),  32'd0);
                @(posedge clk); #1;
                rst = 1'b0;
                quit = 1'b1;
            end
            if (!quit) begin
                @(posedge clk); #1;
                pcieData = $urandom;
                if (mode == 1) biasFull = (k >= 2 && k <= 4);
                if (mode == 2) ena = !(k == 2 || k == 3);
                if (mode == 3) begin
                    start = (k == 3);
                    biasNum = BW'(7); weightNum = WW'(7); layerNum = LW'(7);
                end
            end
        end
        start = 1'b0; biasFull = 1'b0; ena = 1'b1; pcieValid = 1'b0;
    endtask

    initial begin
        #2;
        chk("reset loadState", 32'(loadState), 32'd0);
        chk("reset pcieReady", 32'(pcieReady), 32'd0);
        chk("reset loadDone",  32'(loadDone),  32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; ena = 1'b1;
        repeat (2) @(posedge clk);

        runLoad(2, 3, 4, 0);
        chk("234 bias writes",   32'(nBias),   32'd2);
        chk("234 weight writes", 32'(nWeight), 32'd3);
        chk("234 layer writes",  32'(nLayer),  32'd4);
        chk("234 layer addrs",   32'(layerAddrOk), 32'd1);
        chk("234 done cycle",    32'(doneAt),  32'd10);
        chk("234 done length",   32'(doneLen), 32'd1);
        chk("234 state seq",     seq,          32'h0001_2340);

        runLoad(0, 0, 0, 0);
        chk("000 ready cycles", 32'(nReady), 32'd0);
        chk("000 done cycle",   32'(doneAt), 32'd4);
        chk("000 state seq",    seq,         32'h0001_2340);

        runLoad(4, 0, 0, 1);
        chk("full bias writes",   32'(nBias),        32'd4);
        chk("full stall writes",  32'(stallWrites),  32'd0);
        chk("full weight cycles", 32'(weightCycles), 32'd1);
        chk("full done cycle",    32'(doneAt),       32'd10);

        runLoad(1, 2, 2, 2);
        chk("ena weight writes", 32'(nWeight),      32'd2);
        chk("ena low behaviour", 32'(enaLowBad),    32'd0);
        chk("ena weight cycles", 32'(weightCycles), 32'd4);
        chk("ena done cycle",    32'(doneAt),       32'd8);

        runLoad(2, 3, 4, 3);
        chk("stray start bias",   32'(nBias),   32'd2);
        chk("stray start weight", 32'(nWeight), 32'd3);
        chk("stray start layer",  32'(nLayer),  32'd4);
        chk("stray start done",   32'(doneAt),  32'd10);
        chk("stray start seq",    seq,          32'h0001_2340);

        runLoad(2, 3, 4, 4);
        chk("pre-reset layer writes", 32'(nLayer), 32'd2);
        runLoad(2, 3, 4, 0);
        chk("reload layer writes", 32'(nLayer),      32'd4);
        chk("reload layer addrs",  32'(layerAddrOk), 32'd1);
        chk("reload done cycle",   32'(doneAt),      32'd10);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/conv_load_sequencer.md
# conv_load_sequencer

Sequences the loading of one convolution layer's parameters and input data from the PCIe receive stream into the bias FIFO, the weight FIFO and the layer buffer, in that fixed order. It sits between the PCIe controller and the memory controller. It owns the write-side strobes of all three stores and publishes the 3-bit `loadState` consumed by the memory controller. The block raises a one-cycle `loadDone` pulse when the programmed word counts have all been transferred.

## Interface
- `BIAS_CNT_W`, 8: width of the bias word count.
- `WEIGHT_CNT_W`, 16: width of the weight word count.
- `LAYER_ADDR_W`, 12: width of the layer word count and layer buffer address.
- `DATA_W`, 32: PCIe data word width.

- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ena`  in  1  global enable; low freezes the FSM and counters.
- `start`  in  1  begin a load; sampled only in IDLE.
- `biasNum`  in  BIAS_CNT_W  bias words to load; latched on accepted start.
- `weightNum`  in  WEIGHT_CNT_W  weight words to load; latched on accepted start.
- `layerNum`  in  LAYER_ADDR_W  layer words to load; latched on accepted start.
- `pcieValid`  in  1  PCIe word available.
- `pcieData`  in  DATA_W  PCIe word.
- `pcieReady`  out  1  word accepted this cycle when high together with `pcieValid`.
- `biasFull`  in  1  bias FIFO full.
- `weightFull`  in  1  weight FIFO full.
- `biasWrEn`  out  1  bias FIFO write strobe.
- `weightWrEn`  out  1  weight FIFO write strobe.
- `layerEna`  out  1  layer buffer enable.
- `layerWea`  out  1  layer buffer write (1) / read (0); equals `layerEna` here.
- `layerAddr`  out  LAYER_ADDR_W  layer buffer write address.
- `wrData`  out  DATA_W  `pcieData` passed through to all three stores.
- `loadState`  out  3  current state encoding.
- `loadDone`  out  1  one-cycle completion pulse.

## Operation
- The states and their `loadState` encodings are IDLE=000, BIAS=001, WEIGHT=010, LAYER=011 and DONE=100.
- IDLE:
  - `start && ena` latches the three counts into the remaining-counters `remB`, `remW` and `remL`.
  - It also clears `layerAddr` to 0 and moves to BIAS.
  - `start` in any other state is ignored.
- Accept condition is `acc = ena && pcieValid && pcieReady`.
- `pcieReady` is combinational and depends on the state:
  - BIAS: `ena && remB!=0 && !biasFull`.
  - WEIGHT: `ena && remW!=0 && !weightFull`.
  - LAYER: `ena && remL!=0`. The layer buffer never back-pressures.
  - IDLE and DONE: 0.
- Write strobes are combinational and equal `acc` qualified by state:
  - `biasWrEn` in BIAS.
  - `weightWrEn` in WEIGHT.
  - `layerEna`/`layerWea` in LAYER.
  - Only one strobe can be high in any cycle.
- On each `acc` the active remaining-counter decrements by 1. In LAYER, `layerAddr` also increments by 1 after the write, so the first layer word goes to address 0.
- Transitions:
  - BIAS→WEIGHT when `remB==0`, or when `remB==1 && acc`.
  - WEIGHT→LAYER when `remW==0`, or when `remW==1 && acc`.
  - LAYER→DONE when `remL==0`, or when `remL==1 && acc`.
  - DONE→IDLE unconditionally, if `ena`.
- A zero count occupies its state for exactly one cycle with `pcieReady=0`, then advances.
- `loadDone` is high for the single cycle the FSM is in DONE.
- Counts are not range-checked. `layerNum` equal to 2^LAYER_ADDR_W is not representable.
- When `ena` is low: state, counters and `layerAddr` hold; `pcieReady` and all strobes are 0; `loadDone` holds its state-derived value.
- Full rising mid-burst stalls the transfer with no word lost. The transfer resumes the cycle after full drops.

## Timing
- Reset asynchronously forces:
  - state IDLE, `remB/remW/remL` 0, `layerAddr` 0;
  - outputs `pcieReady`, `biasWrEn`, `weightWrEn`, `layerEna`, `layerWea` and `loadDone` all 0, `loadState` 000.
- Reset mid-burst abandons the load. Words already written stay in the stores. The block restarts only on a new `start`.
- `start` accepted at edge N gives BIAS at N+1. `pcieReady` can be high in the cycle after edge N.
- Each accepted word costs one cycle, and the write strobe occurs in the same cycle as the accept.
- The last word of a stage is accepted at edge M; the next state is in effect from M+1. There is no idle bubble between non-zero stages.
- Minimum load with all counts 0 is BIAS, WEIGHT, LAYER, DONE: `loadDone` high 4 cycles after start is accepted.
- `loadState` is registered and changes only on clock edges.

## Test plan
- Reset mid-LAYER (counts 2/3/4, assert `rst` after 2 layer words) -> all outputs 0, `loadState`=000 immediately. A fresh start then reloads from `layerAddr`=0.
- Counts 2/3/4 with `pcieValid` held high, fulls low -> writes occur as follows:
  - 2 `biasWrEn` cycles, then 3 `weightWrEn`, then 4 `layerEna` at addresses 0..3, back-to-back;
  - `loadDone` is one cycle long, 10 cycles after start;
  - `loadState` sequence is 001,010,011,100,000.
- Counts 0/0/0 -> `pcieReady` never high, `loadDone` 4 cycles after start.
- Counts 4/0/0 with `biasFull` high for 3 cycles after the second bias write -> no bias strobes during full, 4 bias writes total with no loss, then WEIGHT for 1 cycle.
- Counts 1/2/2 with `ena` dropped for 2 cycles during WEIGHT -> `pcieReady`=0 and state held during those cycles, 2 weight writes total.
- `start` pulsed during WEIGHT -> ignored: counters and `loadState` are unaffected.
